cache_hit_select: RTL and testbench

- Hit-detect and read-select stage of a 4-way set-associative cache.
- For one indexed set, it compares the request tag against every way's stored tag using per-way equality comparators.
- Each compare result is gated with that way's valid bit; the resulting one-hot select steers the matching way's line through a one-hot mux.
- It extracts the addressed data word and registers the result for the cache controller's read path.
- Tag/data storage and replacement logic live outside this block.

---
 rtl/cache_hit_select.sv | 114 +++++++++++
 tb/tb_cache_hit_select.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cache_hit_select.sv
// Hit-detect and read-select stage of a set-associative cache: per-way tag compare gated by
// valid, lowest-index priority one-hot line select, word extract, and a one-cycle result register.
module cache_hit_select #(
  parameter int unsigned WAYS            = 4,
  parameter int unsigned TAG_BITS        = 18,
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned OFFSET_BITS     = 6,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned LineBits       = 8 * LINE_SIZE_BYTES,
  localparam int unsigned WayIdxBits     = $clog2(WAYS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_req_valid,
  input  logic [TAG_BITS-1:0]         i_tag,
  input  logic [OFFSET_BITS-1:0]      i_offset,
  input  logic [WAYS*TAG_BITS-1:0]    i_way_tags,
  input  logic [WAYS-1:0]             i_way_valid,
  input  logic [WAYS*LineBits-1:0]    i_way_data,
  output logic [WAYS-1:0]             o_cache_hit,
  output logic                        o_valid,
  output logic                        o_hit,
  output logic [WayIdxBits-1:0]       o_way_idx,
  output logic                        o_multi_hit,
  output logic [DATA_WIDTH-1:0]       o_data
);

  localparam int unsigned Words     = LineBits / DATA_WIDTH;
  localparam int unsigned WordShift = $clog2(DATA_WIDTH / 8);

  logic [WAYS-1:0]        hit;
  logic [WAYS-1:0]        sel;
  logic [LineBits-1:0]    line;
  logic [OFFSET_BITS-1:0] word_idx;
  logic [DATA_WIDTH-1:0]  word;
  logic [WayIdxBits-1:0]  way_idx;
  logic                   multi_hit;

  logic                   valid_q, valid_d;
  logic                   hit_q, hit_d;
  logic [WayIdxBits-1:0]  way_idx_q, way_idx_d;
  logic                   multi_hit_q, multi_hit_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  always_comb begin
    hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = (i_way_tags[w*TAG_BITS +: TAG_BITS] == i_tag) & i_way_valid[w];
    end
  end

  assign o_cache_hit = hit;

  // Two's-complement trick isolates the lowest set bit; anything left over means multiple hits.
  assign sel       = hit & (~hit + WAYS'(1));
  assign multi_hit = |(hit & ~sel);

  always_comb begin
    line    = '0;
    way_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      line    = line | ({LineBits{sel[w]}} & i_way_data[w*LineBits +: LineBits]);
      way_idx = way_idx | (sel[w] ? WayIdxBits'(w) : '0);
    end
  end

  assign word_idx = i_offset >> WordShift;

  always_comb begin
    word = '0;
    for (int k = 0; k < Words; k++) begin
      if (word_idx == OFFSET_BITS'(k)) begin
        word = line[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d     = i_req_valid;
    hit_d       = hit_q;
    way_idx_d   = way_idx_q;
    multi_hit_d = multi_hit_q;
    data_d      = data_q;
    if (i_req_valid) begin
      hit_d       = |hit;
      way_idx_d   = way_idx;
      multi_hit_d = multi_hit;
      data_d      = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      hit_q       <= 1'b0;
      way_idx_q   <= '0;
      multi_hit_q <= 1'b0;
      data_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      hit_q       <= hit_d;
      way_idx_q   <= way_idx_d;
      multi_hit_q <= multi_hit_d;
      data_q      <= data_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_hit       = hit_q;
  assign o_way_idx   = way_idx_q;
  assign o_multi_hit = multi_hit_q;
  assign o_data      = data_q;

endmodule

// File: tb/tb_cache_hit_select.sv
// Directed table-driven bench for cache_hit_select, plus hold, offset sweep and async reset sequences.
module tb_cache_hit_select;

  localparam int unsigned Ways     = 4;
  localparam int unsigned TagBits  = 18;
  localparam int unsigned LineBits = 512;
  localparam int unsigned OffBits  = 6;
  localparam int unsigned DataW    = 32;

  localparam logic [TagBits-1:0] TagA = 18'h0AAAA;
  localparam logic [TagBits-1:0] TagB = 18'h0BBBB;
  localparam logic [TagBits-1:0] TagC = 18'h0CCCC;
  localparam logic [TagBits-1:0] TagD = 18'h0DDDD;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_req_valid;
  logic [TagBits-1:0]        i_tag;
  logic [OffBits-1:0]        i_offset;
  logic [Ways*TagBits-1:0]   i_way_tags;
  logic [Ways-1:0]           i_way_valid;
  logic [Ways*LineBits-1:0]  i_way_data;
  logic [Ways-1:0]           o_cache_hit;
  logic                      o_valid;
  logic                      o_hit;
  logic [1:0]                o_way_idx;
  logic                      o_multi_hit;
  logic [DataW-1:0]          o_data;

  cache_hit_select dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_tag       (i_tag),
    .i_offset    (i_offset),
    .i_way_tags  (i_way_tags),
    .i_way_valid (i_way_valid),
    .i_way_data  (i_way_data),
    .o_cache_hit (o_cache_hit),
    .o_valid     (o_valid),
    .o_hit       (o_hit),
    .o_way_idx   (o_way_idx),
    .o_multi_hit (o_multi_hit),
    .o_data      (o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [Ways*TagBits-1:0] tags;
    logic [Ways-1:0]         valid;
    logic [TagBits-1:0]      tag;
    logic [OffBits-1:0]      offset;
    logic [Ways-1:0]         exp_cache_hit;
    logic                    exp_hit;
    logic [1:0]              exp_idx;
    logic                    exp_multi;
    logic [DataW-1:0]        exp_data;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [8];

  function automatic logic [Ways*TagBits-1:0] tags4(input logic [TagBits-1:0] w0,
                                                   input logic [TagBits-1:0] w1,
                                                   input logic [TagBits-1:0] w2,
                                                   input logic [TagBits-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    i_way_tags  = v.tags;
    i_way_valid = v.valid;
    i_tag       = v.tag;
    i_offset    = v.offset;
    i_req_valid = 1'b1;
    #1;
    check($sformatf("v%0d cache_hit", id), 64'(o_cache_hit), 64'(v.exp_cache_hit));
    @(posedge clk);
    #1;
    check($sformatf("v%0d valid", id), 64'(o_valid), 64'(1'b1));
    check($sformatf("v%0d hit", id), 64'(o_hit), 64'(v.exp_hit));
    check($sformatf("v%0d way_idx", id), 64'(o_way_idx), 64'(v.exp_idx));
    check($sformatf("v%0d multi", id), 64'(o_multi_hit), 64'(v.exp_multi));
    check($sformatf("v%0d data", id), 64'(o_data), 64'(v.exp_data));
  endtask

  initial begin
    vec_t sw;
    // Word k of way w holds 0xC00w000k; one word in way2 is overridden.
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 16; k++) begin
        i_way_data[w*LineBits + k*DataW +: DataW] = 32'hC000_0000 | (32'(w) << 16) | 32'(k);
      end
    end
    i_way_data[2*LineBits + 2*DataW +: DataW] = 32'hDEAD_BEEF;

    vecs[0] = '{tags4(TagA, TagB, TagC, TagD), 4'b1111, TagC, 6'h08,
                4'b0100, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{tags4(TagA, TagB, TagC, TagD), 4'b1101, TagB, 6'h08,
                4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[2] = '{tags4(TagA, TagB, TagC, TagB), 4'b1111, TagB, 6'h14,
                4'b1010, 1'b1, 2'd1, 1'b1, 32'hC001_0005};
    vecs[3] = '{tags4(TagA, TagB, TagC, TagD), 4'b1111, 18'h3FFFF, 6'h00,
                4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[4] = '{tags4(TagA, TagA, TagA, TagA), 4'b1111, TagA, 6'h3C,
                4'b1111, 1'b1, 2'd0, 1'b1, 32'hC000_000F};
    vecs[5] = '{tags4(TagA, TagB, TagC, TagD), 4'b1111, TagD, 6'h3F,
                4'b1000, 1'b1, 2'd3, 1'b0, 32'hC003_000F};
    // Tag differs only in the MSB: full-width compare must miss.
    vecs[6] = '{tags4(TagA, TagB, TagC, 18'h2DDDD), 4'b1111, TagD, 6'h00,
                4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[7] = '{tags4(TagA, TagA, TagA, TagA), 4'b1100, TagA, 6'h04,
                4'b1100, 1'b1, 2'd2, 1'b1, 32'hC002_0001};

    rst         = 1'b1;
    i_req_valid = 1'b1;
    i_tag       = TagA;
    i_offset    = '0;
    i_way_tags  = tags4(TagA, TagB, TagC, TagD);
    i_way_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 64'(o_valid), 64'(0));
    check("reset hit", 64'(o_hit), 64'(0));
    check("reset data", 64'(o_data), 64'(0));
    check("reset cache_hit comb", 64'(o_cache_hit), 64'(4'b0001));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply(vecs[i], i);

    // Offset sweep on a way0 hit, including an unaligned top offset.
    for (int k = 0; k < 17; k++) begin
      sw = '{tags4(TagA, TagB, TagC, TagD), 4'b1111, TagA, (k == 16) ? 6'h3F : 6'(4 * k),
             4'b0001, 1'b1, 2'd0, 1'b0, 32'hC000_0000 | 32'((k == 16) ? 15 : k)};
      apply(sw, 100 + k);
    end

    // Hold: strobe low with changed inputs keeps prior results.
    apply(vecs[0], 200);
    @(negedge clk);
    i_req_valid = 1'b0;
    i_tag       = 18'h3FFFF;
    i_offset    = 6'h00;
    #1;
    check("hold cache_hit comb", 64'(o_cache_hit), 64'(0));
    @(posedge clk);
    #1;
    check("hold valid", 64'(o_valid), 64'(0));
    check("hold hit", 64'(o_hit), 64'(1));
    check("hold way_idx", 64'(o_way_idx), 64'(2));
    check("hold data", 64'(o_data), 64'(32'hDEAD_BEEF));

    // Async reset between edges during a hit.
    apply(vecs[0], 300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("areset valid", 64'(o_valid), 64'(0));
    check("areset hit", 64'(o_hit), 64'(0));
    check("areset way_idx", 64'(o_way_idx), 64'(0));
    check("areset data", 64'(o_data), 64'(0));
    check("areset cache_hit comb", 64'(o_cache_hit), 64'(4'b0100));
    @(posedge clk);
    #1;
    check("areset req lost", 64'(o_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    apply(vecs[2], 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
